ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_pkg.sv | 30 +++
 rtl/fwd_mux.sv | 40 ++++
 rtl/ex_operand_stage.sv | 125 ++++++++++++
 tb/tb_ex_operand_stage.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types for the EX operand stage: ALU opcodes, default widths and the
// ID/EX pipeline register layout.
package ex_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_RA_W  = 5;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic                 valid;
    logic [DEF_RA_W-1:0]  rsAddr;
    logic [DEF_RA_W-1:0]  rtAddr;
    logic [DEF_WIDTH-1:0] rsData;
    logic [DEF_WIDTH-1:0] rtData;
    logic [DEF_WIDTH-1:0] imm;
    logic                 useImm;
    alu_op_e              aluOp;
    logic [DEF_RA_W-1:0]  rdAddr;
    logic                 regWrite;
    logic                 memRead;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand select for one source: EX/MEM, then MEM/WB, then register data.
// EX_OPERAND_FWD_EN undefined: the register data passes straight through.
module fwd_mux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RA_W  = 5
) (
  input  logic [RA_W-1:0]  srcAddr,
  input  logic [WIDTH-1:0] regData,
  input  logic [RA_W-1:0]  exmemRd,
  input  logic             exmemWe,
  input  logic [WIDTH-1:0] exmemResult,
  input  logic [RA_W-1:0]  memwbRd,
  input  logic             memwbWe,
  input  logic [WIDTH-1:0] memwbResult,
  output logic [WIDTH-1:0] operand
);

`ifdef EX_OPERAND_FWD_EN
  logic exmemHit, memwbHit;

  // r0 is hard-wired zero, so it is never a forwarding source.
  assign exmemHit = exmemWe & (exmemRd != '0) & (exmemRd == srcAddr);
  assign memwbHit = memwbWe & (memwbRd != '0) & (memwbRd == srcAddr);

  always_comb begin
    operand = regData;
    if (exmemHit) begin
      operand = exmemResult;
    end else if (memwbHit) begin
      operand = memwbResult;
    end
  end
`else
  logic unusedFwd;

  assign unusedFwd = ^{srcAddr, exmemRd, exmemWe, exmemResult, memwbRd, memwbWe, memwbResult};
  assign operand   = regData;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with hazard stall and operand forwarding into the ALU.
// EX_OPERAND_FWD_EN defined: forward and stall on load-use only; undefined: stall on any match.
module ex_operand_stage
  import ex_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RA_W  = DEF_RA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs_addr,
  input  logic [RA_W-1:0]  id_rt_addr,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_use_imm,
  input  logic [2:0]       id_alu_op,
  input  logic [RA_W-1:0]  id_rd_addr,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  input  logic [RA_W-1:0]  exmem_rd_addr,
  input  logic             exmem_reg_write,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic [RA_W-1:0]  memwb_rd_addr,
  input  logic             memwb_reg_write,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             stall,
  output logic             ex_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [RA_W-1:0]  ex_rd_addr,
  output logic             ex_reg_write,
  output logic             ex_mem_read
);

  id_ex_t           idExQ, idExD;
  logic             hazard;
  logic [WIDTH-1:0] rsOperand, rtOperand;

`ifdef EX_OPERAND_FWD_EN
  assign hazard = id_valid & idExQ.valid & idExQ.memRead & (idExQ.rdAddr != '0) &
                  ((id_rs_addr == idExQ.rdAddr) | (~id_use_imm & (id_rt_addr == idExQ.rdAddr)));
`else
  logic rsBusy, rtBusy;

  // Without forwarding, any in-flight writer of a source register blocks issue.
  always_comb begin
    rsBusy = (id_rs_addr != '0) &
             ((idExQ.valid & idExQ.regWrite & (id_rs_addr == idExQ.rdAddr)) |
              (exmem_reg_write & (id_rs_addr == exmem_rd_addr)) |
              (memwb_reg_write & (id_rs_addr == memwb_rd_addr)));
    rtBusy = (id_rt_addr != '0) &
             ((idExQ.valid & idExQ.regWrite & (id_rt_addr == idExQ.rdAddr)) |
              (exmem_reg_write & (id_rt_addr == exmem_rd_addr)) |
              (memwb_reg_write & (id_rt_addr == memwb_rd_addr)));
  end

  assign hazard = id_valid & (rsBusy | (~id_use_imm & rtBusy));
`endif

  // Reset and flush both mask the stall request immediately.
  assign stall = rst_n & ~flush & hazard;

  // Anything that is not a real, issuing instruction loads an all-zero bubble.
  always_comb begin
    idExD = '0;
    if (id_valid && !flush && !hazard) begin
      idExD.valid    = 1'b1;
      idExD.rsAddr   = id_rs_addr;
      idExD.rtAddr   = id_rt_addr;
      idExD.rsData   = id_rs_data;
      idExD.rtData   = id_rt_data;
      idExD.imm      = id_imm;
      idExD.useImm   = id_use_imm;
      idExD.aluOp    = alu_op_e'(id_alu_op);
      idExD.rdAddr   = id_rd_addr;
      idExD.regWrite = id_reg_write;
      idExD.memRead  = id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idExQ <= '0;
    end else begin
      idExQ <= idExD;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rs (
    .srcAddr     (idExQ.rsAddr),
    .regData     (idExQ.rsData),
    .exmemRd     (exmem_rd_addr),
    .exmemWe     (exmem_reg_write),
    .exmemResult (exmem_result),
    .memwbRd     (memwb_rd_addr),
    .memwbWe     (memwb_reg_write),
    .memwbResult (memwb_result),
    .operand     (rsOperand)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_rt (
    .srcAddr     (idExQ.rtAddr),
    .regData     (idExQ.rtData),
    .exmemRd     (exmem_rd_addr),
    .exmemWe     (exmem_reg_write),
    .exmemResult (exmem_result),
    .memwbRd     (memwb_rd_addr),
    .memwbWe     (memwb_reg_write),
    .memwbResult (memwb_result),
    .operand     (rtOperand)
  );

  assign ex_valid     = idExQ.valid;
  assign alu_a        = rsOperand;
  assign alu_b        = idExQ.useImm ? idExQ.imm : rtOperand;
  assign alu_op       = idExQ.aluOp;
  assign ex_rd_addr   = idExQ.rdAddr;
  assign ex_reg_write = idExQ.regWrite;
  assign ex_mem_read  = idExQ.memRead;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Random and directed bench for ex_operand_stage against a behavioural model of
// the instruction sitting in EX; honours EX_OPERAND_FWD_EN like the design.
module tb_ex_operand_stage;

  logic        clk, rst_n;
  logic        id_valid, id_use_imm, id_reg_write, id_mem_read, flush;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, exmem_rd_addr, memwb_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic [2:0]  id_alu_op;
  logic        exmem_reg_write, memwb_reg_write;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  ex_rd_addr;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .exmem_rd_addr(exmem_rd_addr), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_rd_addr(memwb_rd_addr),
    .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result), .stall(stall),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instruction currently held in EX (v=0 means nothing there).
  typedef struct {
    bit          v;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    bit          ui, rw, mr;
    logic [2:0]  op;
  } instr_t;

  instr_t exM, none;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hit(input logic [4:0] a, input logic [4:0] w, input bit we);
    return we && (w != 5'd0) && (a == w);
  endfunction

  function automatic logic [31:0] pick(input logic [4:0] a, input logic [31:0] regd);
`ifdef EX_OPERAND_FWD_EN
    if (hit(a, exmem_rd_addr, exmem_reg_write)) return exmem_result;
    if (hit(a, memwb_rd_addr, memwb_reg_write)) return memwb_result;
`endif
    return regd;
  endfunction

  function automatic bit busy(input logic [4:0] a);
    return hit(a, exM.rd, exM.v && exM.rw) || hit(a, exmem_rd_addr, exmem_reg_write) ||
           hit(a, memwb_rd_addr, memwb_reg_write);
  endfunction

  function automatic bit expStall();
    bit h;
`ifdef EX_OPERAND_FWD_EN
    h = exM.v && exM.mr && (exM.rd != 5'd0) &&
        ((id_rs_addr == exM.rd) || (!id_use_imm && (id_rt_addr == exM.rd)));
`else
    h = busy(id_rs_addr) || (!id_use_imm && busy(id_rt_addr));
`endif
    return rst_n && !flush && id_valid && h;
  endfunction

  always @(posedge clk) begin
    if (rst_n) begin
      if (id_valid && !flush && !expStall()) begin
        exM = '{v: 1'b1, rs: id_rs_addr, rt: id_rt_addr, rd: id_rd_addr, rsd: id_rs_data,
                rtd: id_rt_data, imm: id_imm, ui: id_use_imm, rw: id_reg_write,
                mr: id_mem_read, op: id_alu_op};
      end else begin
        exM = none;
      end
    end
  end

  always @(negedge rst_n) exM = none;

  always @(negedge clk) begin
    chk("stall", {31'd0, stall}, {31'd0, expStall()});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, exM.v});
    chk("alu_a", alu_a, exM.v ? pick(exM.rs, exM.rsd) : 32'd0);
    chk("alu_b", alu_b, exM.v ? (exM.ui ? exM.imm : pick(exM.rt, exM.rtd)) : 32'd0);
    chk("alu_op", {29'd0, alu_op}, exM.v ? {29'd0, exM.op} : 32'd0);
    chk("ex_rd_addr", {27'd0, ex_rd_addr}, exM.v ? {27'd0, exM.rd} : 32'd0);
    chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, exM.v && exM.rw});
    chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, exM.v && exM.mr});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_use_imm = 0; id_alu_op = 0; id_rd_addr = 0; id_reg_write = 0;
    id_mem_read = 0; flush = 0; exmem_rd_addr = 0; exmem_reg_write = 0; exmem_result = 0;
    memwb_rd_addr = 0; memwb_reg_write = 0; memwb_result = 0;
  endtask

  task automatic setId(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [31:0] imm, input logic ui,
                       input logic [2:0] op, input logic [4:0] rd, input logic rw,
                       input logic mr);
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rs_data = rsd; id_rt_data = rtd;
    id_imm = imm; id_use_imm = ui; id_alu_op = op; id_rd_addr = rd; id_reg_write = rw;
    id_mem_read = mr;
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_alu_b"}, alu_b, 32'd0);
    chk({tag, "_alu_op"}, {29'd0, alu_op}, 32'd0);
    chk({tag, "_rd"}, {27'd0, ex_rd_addr}, 32'd0);
    chk({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
    chk({tag, "_mr"}, {31'd0, ex_mem_read}, 32'd0);
  endtask

  initial begin
    none  = '{default: 0};
    exM   = none;
    rst_n = 1'b0;
    idle();
    #12;
    chkAllZero("reset");
    rst_n = 1'b1;

`ifdef EX_OPERAND_FWD_EN
    // EX/MEM result reaches alu_a one cycle after issue.
    tick(); setId(5'd3, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0);
    tick(); idle(); exmem_rd_addr = 5'd3; exmem_reg_write = 1; exmem_result = 32'd25;
    @(negedge clk); chk("fwd_exmem", alu_a, 32'd25); chk("fwd_exmem_v", {31'd0, ex_valid}, 1);

    // EX/MEM has priority over MEM/WB.
    tick(); idle(); setId(5'd4, 5'd0, 32'd1, 32'd0, 32'd0, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0);
    tick(); idle(); exmem_rd_addr = 5'd4; exmem_reg_write = 1; exmem_result = 32'd7;
    memwb_rd_addr = 5'd4; memwb_reg_write = 1; memwb_result = 32'd9;
    @(negedge clk); chk("fwd_prio", alu_a, 32'd7);

    // r0 writers are ignored.
    tick(); idle(); setId(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 5'd7, 1'b1, 1'b0);
    tick(); idle(); exmem_rd_addr = 5'd0; exmem_reg_write = 1; exmem_result = 32'd99;
    memwb_rd_addr = 5'd0; memwb_reg_write = 1; memwb_result = 32'd99;
    @(negedge clk); chk("r0_alu_a", alu_a, 32'd0); chk("r0_stall", {31'd0, stall}, 0);

    // Load-use on rt: one stall, one bubble, then issue with the MEM/WB value.
    tick(); idle(); setId(5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 1'b1, 3'd0, 5'd5, 1'b1, 1'b1);
    tick(); idle(); setId(5'd6, 5'd5, 32'd0, 32'h11, 32'd0, 1'b0, 3'd1, 5'd8, 1'b1, 1'b0);
    @(negedge clk); chk("lu_stall", {31'd0, stall}, 1);
    tick(); exmem_rd_addr = 5'd5; exmem_reg_write = 1; exmem_result = 32'h33;
    @(negedge clk); chk("lu_bubble", {31'd0, ex_valid}, 0); chk("lu_unstall", {31'd0, stall}, 0);
    tick(); exmem_reg_write = 0; memwb_rd_addr = 5'd5; memwb_reg_write = 1;
    memwb_result = 32'h55;
    @(negedge clk); chk("lu_issue", {31'd0, ex_valid}, 1); chk("lu_alu_b", alu_b, 32'h55);
    chk("lu_op", {29'd0, alu_op}, 32'd1);

    // Flush beats the load-use stall.
    tick(); idle(); setId(5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 1'b1, 3'd0, 5'd5, 1'b1, 1'b1);
    tick(); idle(); setId(5'd6, 5'd5, 32'd0, 32'h11, 32'd0, 1'b0, 3'd1, 5'd8, 1'b1, 1'b0);
    flush = 1;
    @(negedge clk); chk("fl_stall", {31'd0, stall}, 0);
    tick(); idle();
    @(negedge clk); chk("fl_bubble", {31'd0, ex_valid}, 0); chk("fl_alu_a", alu_a, 0);
`else
    // Writer of r2 walks EX -> EX/MEM -> MEM/WB; the reader waits three cycles.
    tick(); idle(); setId(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 3'd0, 5'd2, 1'b1, 1'b0);
    tick(); idle(); setId(5'd2, 5'd0, 32'h22, 32'd0, 32'd5, 1'b1, 3'd2, 5'd9, 1'b1, 1'b0);
    @(negedge clk); chk("nf_stall1", {31'd0, stall}, 1);
    tick(); exmem_rd_addr = 5'd2; exmem_reg_write = 1; exmem_result = 32'h77;
    @(negedge clk); chk("nf_stall2", {31'd0, stall}, 1); chk("nf_bub2", {31'd0, ex_valid}, 0);
    tick(); exmem_reg_write = 0; memwb_rd_addr = 5'd2; memwb_reg_write = 1;
    @(negedge clk); chk("nf_stall3", {31'd0, stall}, 1); chk("nf_bub3", {31'd0, ex_valid}, 0);
    tick(); memwb_reg_write = 0;
    @(negedge clk); chk("nf_release", {31'd0, stall}, 0);
    tick(); idle();
    @(negedge clk); chk("nf_issue", {31'd0, ex_valid}, 1); chk("nf_alu_a", alu_a, 32'h22);
    chk("nf_alu_b", alu_b, 32'd5);
`endif

    // Reset pulse while stalled clears everything at once; next edge issues normally.
    tick(); idle(); setId(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 3'd0, 5'd2, 1'b1, 1'b1);
    tick(); idle(); setId(5'd2, 5'd0, 32'h44, 32'd0, 32'd0, 1'b0, 3'd3, 5'd9, 1'b1, 1'b0);
    @(negedge clk); chk("rs_pre_stall", {31'd0, stall}, 1);
    #2 rst_n = 1'b0;
    #1 chkAllZero("rst_mid");
    #1 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_issue", {31'd0, ex_valid}, 1); chk("rst_alu_a", alu_a, 32'h44);

    // Random traffic over a small register set so hits are common.
    repeat (400) begin
      tick();
      id_valid        = ($urandom_range(0, 3) != 0);
      id_rs_addr      = 5'($urandom_range(0, 3));
      id_rt_addr      = 5'($urandom_range(0, 3));
      id_rd_addr      = 5'($urandom_range(0, 3));
      id_rs_data      = $urandom;
      id_rt_data      = $urandom;
      id_imm          = $urandom;
      id_use_imm      = 1'($urandom_range(0, 1));
      id_alu_op       = 3'($urandom_range(0, 4));
      id_reg_write    = 1'($urandom_range(0, 1));
      id_mem_read     = ($urandom_range(0, 2) == 0);
      flush           = ($urandom_range(0, 9) == 0);
      exmem_rd_addr   = 5'($urandom_range(0, 3));
      exmem_reg_write = 1'($urandom_range(0, 1));
      exmem_result    = $urandom;
      memwb_rd_addr   = 5'($urandom_range(0, 3));
      memwb_reg_write = 1'($urandom_range(0, 1));
      memwb_result    = $urandom;
    end
    tick(); idle();
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
